// File: rtl/scan_decoder_if.sv
// Select-bus bundle between a controller (master) and the scan decoder (slave).
// Carries the control strobes in and the registered one-hot select, address and wrap pulse out.
interface scan_decoder_if #(
    parameter int ADDR_W = 4
);
    localparam int OUT_W = 1 << ADDR_W;

    logic              en;
    logic              mode;
    logic              load;
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  out;
    logic [ADDR_W-1:0] cur_addr;
    logic              wrap;

    modport master (
        output en, mode, load, addr,
        input  out, cur_addr, wrap
    );

    modport slave (
        input  en, mode, load, addr,
        output out, cur_addr, wrap
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-load and dwell-timed auto-scan; 1-cycle latency from inputs to out.
// No backpressure: every input is sampled on every edge and all outputs come straight from flops.
module scan_decoder #(
    parameter int ADDR_W = 4,
    parameter int DWELL  = 4
) (
    input  logic           clk,
    input  logic           rst,
    scan_decoder_if.slave  bus
);
    localparam int OUT_W = 1 << ADDR_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              wrap_q, wrap_d;
    logic              mode_q, mode_d;

    always_comb begin
        cur_addr_d = cur_addr_q;
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        mode_d     = bus.mode;

        if (bus.load) begin
            cur_addr_d = bus.addr;
            cnt_d      = '0;
        end else if (!bus.mode || !mode_q) begin
            // Direct mode, or the first scan edge after leaving direct mode:
            // the dwell restarts so the current address gets a full DWELL.
            cnt_d = '0;
        end else if (bus.en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d      = '0;
                cur_addr_d = cur_addr_q + 1'b1;
                wrap_d     = (cur_addr_q == ADDR_LAST);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Decode the next address so out and cur_addr always match in the same cycle.
        out_d = bus.en ? (OUT_W'(1) << cur_addr_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_q <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            wrap_q     <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            cur_addr_q <= cur_addr_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            wrap_q     <= wrap_d;
            mode_q     <= mode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(out_q));
        end
    end

    assign bus.out      = out_q;
    assign bus.cur_addr = cur_addr_q;
    assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: a 4-bit/DWELL=4 instance and a 2-bit/DWELL=1 instance against a behavioural model.
module tb_scan_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    scan_decoder_if #(.ADDR_W(4)) ifa ();
    scan_decoder_if #(.ADDR_W(2)) ifb ();

    scan_decoder #(.ADDR_W(4), .DWELL(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    scan_decoder #(.ADDR_W(2), .DWELL(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: address plus cycles of dwell still owed to it.
    typedef struct {
        int addr;
        int left;
        bit pmode;
        int outv;
        bit wrap;
    } mst_t;

    function automatic mst_t model_step(input mst_t s, input int n, input int dwell,
                                        input bit r, input bit en, input bit mode,
                                        input bit ld, input int a);
        mst_t t;
        t      = s;
        t.wrap = 1'b0;
        if (r) begin
            t.addr  = 0;
            t.left  = dwell;
            t.pmode = 1'b0;
            t.outv  = 0;
            return t;
        end
        if (ld) begin
            t.addr = a;
            t.left = dwell;
        end else if (!mode || !s.pmode) begin
            t.left = dwell;
        end else if (en) begin
            t.left = t.left - 1;
            if (t.left == 0) begin
                t.wrap = (s.addr == n - 1);
                t.addr = (s.addr + 1) % n;
                t.left = dwell;
            end
        end
        t.pmode = mode;
        t.outv  = en ? (1 << t.addr) : 0;
        return t;
    endfunction

    mst_t ma, mb;
    bit   va = 1'b0;
    bit   vb = 1'b0;

    always @(posedge clk) begin
        ma <= model_step(ma, 16, 4, rst_a, ifa.en, ifa.mode, ifa.load, int'(ifa.addr));
        mb <= model_step(mb, 4, 1, rst_b, ifb.en, ifb.mode, ifb.load, int'(ifb.addr));
        va <= va | rst_a;
        vb <= vb | rst_b;
    end

    always @(negedge clk) begin
        if (va) begin
            check("a.out", ifa.out, ma.outv);
            check("a.cur_addr", ifa.cur_addr, ma.addr);
            check("a.wrap", ifa.wrap, ma.wrap);
            check("a.onehot", $countones(ifa.out) <= 1, 1);
        end
        if (vb) begin
            check("b.out", ifb.out, mb.outv);
            check("b.cur_addr", ifb.cur_addr, mb.addr);
            check("b.wrap", ifb.wrap, mb.wrap);
        end
    end

    initial begin
        logic [15:0] one16;
        int n, wraps, w1, w2, n0;
        int bexp [9];
        bit bw   [9];
        one16 = 16'h1;
        bexp  = '{1, 2, 4, 8, 1, 2, 4, 8, 1};
        bw    = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

        rst_a = 1'b1; rst_b = 1'b1;
        ifa.en = 1'b0; ifa.mode = 1'b0; ifa.load = 1'b0; ifa.addr = '0;
        ifb.en = 1'b1; ifb.mode = 1'b1; ifb.load = 1'b0; ifb.addr = '0;
        repeat (2) @(negedge clk);
        check("reset.out", ifa.out, 0);
        check("reset.cur_addr", ifa.cur_addr, 0);
        check("reset.wrap", ifa.wrap, 0);

        // Direct sweep
        rst_a = 1'b0; ifa.en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            ifa.load = 1'b1; ifa.addr = 4'(a);
            @(negedge clk);
            check("direct.out", ifa.out, one16 << a);
            check("direct.cur_addr", ifa.cur_addr, a);
        end
        ifa.load = 1'b0;
        repeat (3) @(negedge clk);
        check("direct.hold", ifa.cur_addr, 15);

        // Scan from reset: 4-cycle steps, wrap on 15->0, period 64
        rst_a = 1'b1; @(negedge clk);
        rst_a = 1'b0; ifa.mode = 1'b1; ifa.en = 1'b1;
        wraps = 0; w1 = 0; w2 = 0; n0 = 0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            if (k == 1) check("scan.first_out", ifa.out, 16'h0001);
            if (k == 5) check("scan.second_addr", ifa.cur_addr, 1);
            if (ifa.wrap) begin
                wraps++;
                if (w1 == 0) w1 = k; else w2 = k;
            end
            if (k <= 8 && ifa.cur_addr == 0) n0++;
        end
        check("scan.dwell", n0, 4);
        check("scan.wraps", wraps, 2);
        check("scan.first_wrap", w1, 65);
        check("scan.period", w2 - w1, 64);

        // Drop en on the first cycle of address 5
        for (int k = 0; k < 100 && ifa.cur_addr != 5; k++) @(negedge clk);
        check("freeze.reach", ifa.cur_addr, 5);
        ifa.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("freeze.out", ifa.out, 0);
            check("freeze.cur_addr", ifa.cur_addr, 5);
        end
        ifa.en = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifa.out != 16'h0020) break;
            n++;
        end
        check("resume.dwell", n, 3);
        check("resume.next", ifa.out, 16'h0040);

        // Load coinciding with an advance (last dwell cycle of address 6)
        repeat (3) @(negedge clk);
        ifa.load = 1'b1; ifa.addr = 4'd12;
        @(negedge clk);
        ifa.load = 1'b0;
        check("load.cur_addr", ifa.cur_addr, 12);
        check("load.out", ifa.out, 16'h1000);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifa.cur_addr != 12) break;
            n++;
        end
        check("load.dwell", n, 4);
        check("load.next", ifa.cur_addr, 13);

        // Load while disabled
        ifa.en = 1'b0; ifa.load = 1'b1; ifa.addr = 4'd3;
        @(negedge clk);
        ifa.load = 1'b0;
        check("load_dis.cur_addr", ifa.cur_addr, 3);
        check("load_dis.out", ifa.out, 0);
        @(negedge clk);
        check("load_dis.hold", ifa.cur_addr, 3);

        // Reset mid-scan at address 9
        ifa.en = 1'b1;
        for (int k = 0; k < 100 && ifa.cur_addr != 9; k++) @(negedge clk);
        check("rst_mid.reach", ifa.cur_addr, 9);
        rst_a = 1'b1;
        @(negedge clk);
        check("rst_mid.out", ifa.out, 0);
        check("rst_mid.cur_addr", ifa.cur_addr, 0);
        check("rst_mid.wrap", ifa.wrap, 0);
        rst_a = 1'b0;
        @(negedge clk);
        check("rst_rel.out", ifa.out, 16'h0001);

        // Scan to direct: address holds
        ifa.mode = 1'b0;
        repeat (6) @(negedge clk);
        check("to_direct.cur_addr", ifa.cur_addr, 0);
        check("to_direct.out", ifa.out, 16'h0001);

        // Two-bit decoder with DWELL=1
        rst_b = 1'b1; @(negedge clk);
        rst_b = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("dw1.out", ifb.out, bexp[k]);
            check("dw1.wrap", ifb.wrap, bw[k]);
        end

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
